// File: rtl/nes_frame_scaler.sv
// NES picture scaler: stores 256-pixel PPU scanlines in a two-line ping-pong buffer and
// replicates each pixel 3x3 into a centred 768x720 window of the 1024x768 VGA raster.
module nes_frame_scaler #(
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned X_OFF        = 128,
    parameter int unsigned Y_OFF        = 24,
    parameter int unsigned SCALE        = 3,
    parameter              PALETTE_FILE = "nes_palette.hex"
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_valid,
    input  logic [7:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [5:0]  pix_idx,
    input  logic [10:0] DrawX,
    input  logic [10:0] DrawY,
    input  logic        blank,
    input  logic        underrun_clr,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        blank_out,
    output logic        underrun
);

    localparam logic [10:0] X_START  = 11'(X_OFF);
    localparam logic [10:0] X_LIMIT  = 11'(H_ACTIVE);
    localparam logic [10:0] Y_START  = 11'(Y_OFF);
    localparam logic [10:0] Y_LIMIT  = 11'(V_ACTIVE);
    localparam logic [1:0]  SUB_LAST = 2'(SCALE - 1);

    // Standard 2C02 palette baked in; PALETTE_FILE names the equivalent init file.
    localparam logic [23:0] PALETTE [64] = '{
        24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC, 24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
        24'h503000, 24'h007800, 24'h006800, 24'h005800, 24'h004058, 24'h000000, 24'h000000, 24'h000000,
        24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC, 24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
        24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844, 24'h008888, 24'h000000, 24'h000000, 24'h000000,
        24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8, 24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
        24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898, 24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
        24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8, 24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
        24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8, 24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
    };

    if ($bits(PALETTE_FILE) == 0) begin : g_no_palette_name
    end

    logic [5:0]      line_mem [2][256];
    logic            wr_en;
    logic [1:0]      tag_valid_q, tag_valid_d;
    logic [1:0][7:0] tag_line_q, tag_line_d;

    logic [10:0] drawy_q, drawy_d;
    logic        y_change;
    logic [7:0]  ycnt_q, ycnt_d, xcnt_q, xcnt_d;
    logic [1:0]  ysub_q, ysub_d, xsub_q, xsub_d;
    logic        yact_q, yact_d, xact_q, xact_d;

    logic [5:0]  rd_idx_q, rd_idx_d;
    logic        hit_q, hit_d, in_win_q, in_win_d, blank1_q, blank1_d;
    logic [23:0] rgb_q, rgb_d;
    logic        blank_out_q, blank_out_d, underrun_q, underrun_d;

    always_comb begin
        wr_en       = pix_valid && (pix_y < 9'd240);
        tag_valid_d = tag_valid_q;
        tag_line_d  = tag_line_q;
        if (wr_en && pix_x == 8'hFF) begin
            tag_valid_d[pix_y[0]] = 1'b1;
            tag_line_d[pix_y[0]]  = pix_y[7:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) line_mem[pix_y[0]][pix_x] <= pix_idx;
    end

    // Counters produce the values for the current DrawX/DrawY so stage 1 sees them without extra delay.
    always_comb begin
        drawy_d  = DrawY;
        y_change = DrawY != drawy_q;
        ycnt_d   = ycnt_q;
        ysub_d   = ysub_q;
        yact_d   = yact_q;
        if (y_change && DrawY == Y_START) begin
            ycnt_d = '0;
            ysub_d = '0;
            yact_d = 1'b1;
        end else if (DrawY == '0 || DrawY >= Y_LIMIT) begin
            yact_d = 1'b0;
        end else if (y_change && yact_q) begin
            if (ysub_q == SUB_LAST) begin
                ysub_d = '0;
                if (ycnt_q == 8'd239) yact_d = 1'b0;
                else                  ycnt_d = ycnt_q + 8'd1;
            end else begin
                ysub_d = ysub_q + 2'd1;
            end
        end
    end

    always_comb begin
        xcnt_d = xcnt_q;
        xsub_d = xsub_q;
        xact_d = xact_q;
        if (DrawX == X_START) begin
            xcnt_d = '0;
            xsub_d = '0;
            xact_d = yact_d;
        end else if (DrawX >= X_LIMIT) begin
            xact_d = 1'b0;
        end else if (xact_q) begin
            if (xsub_q == SUB_LAST) begin
                xsub_d = '0;
                if (xcnt_q == 8'hFF) xact_d = 1'b0;
                else                 xcnt_d = xcnt_q + 8'd1;
            end else begin
                xsub_d = xsub_q + 2'd1;
            end
        end
    end

    always_comb begin
        rd_idx_d    = line_mem[ycnt_d[0]][xcnt_d];
        hit_d       = xact_d && tag_valid_q[ycnt_d[0]] && (tag_line_q[ycnt_d[0]] == ycnt_d);
        in_win_d    = xact_d;
        blank1_d    = blank;
        rgb_d       = (hit_q && blank1_q) ? PALETTE[rd_idx_q] : '0;
        blank_out_d = blank1_q;
        underrun_d  = underrun_q;
        if (underrun_clr)                       underrun_d = 1'b0;
        if (in_win_q && !hit_q && blank1_q)     underrun_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            tag_valid_q <= '0;
            tag_line_q  <= '0;
            drawy_q     <= '0;
            ycnt_q      <= '0;
            ysub_q      <= '0;
            yact_q      <= 1'b0;
            xcnt_q      <= '0;
            xsub_q      <= '0;
            xact_q      <= 1'b0;
            rd_idx_q    <= '0;
            hit_q       <= 1'b0;
            in_win_q    <= 1'b0;
            blank1_q    <= 1'b0;
            rgb_q       <= '0;
            blank_out_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_line_q  <= tag_line_d;
            drawy_q     <= drawy_d;
            ycnt_q      <= ycnt_d;
            ysub_q      <= ysub_d;
            yact_q      <= yact_d;
            xcnt_q      <= xcnt_d;
            xsub_q      <= xsub_d;
            xact_q      <= xact_d;
            rd_idx_q    <= rd_idx_d;
            hit_q       <= hit_d;
            in_win_q    <= in_win_d;
            blank1_q    <= blank1_d;
            rgb_q       <= rgb_d;
            blank_out_q <= blank_out_d;
            underrun_q  <= underrun_d;
        end
    end

    assign red       = rgb_q[23:16];
    assign green     = rgb_q[15:8];
    assign blue      = rgb_q[7:0];
    assign blank_out = blank_out_q;
    assign underrun  = underrun_q;

endmodule
